// File: rtl/serial_frame_tx.sv
// Multi-channel framed serial transmitter: start bit, MSG_W data bits, stop bit.
// Holds CHANNELS message registers loaded from the switch bus and shifts one out.
module serial_frame_tx #(
    parameter int unsigned MSG_W    = 10,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DIV      = 1,
    localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [SEL_W-1:0] sel,
    input  logic [MSG_W-1:0] SW,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             abort,
    output logic             out,
    output logic             busy,
    output logic             done,
    output logic [SEL_W-1:0] active_ch
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = $clog2(MSG_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    // Counter value one cycle before the end of a bit period (only used when DIV > 1)
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'((DIV > 1) ? DIV - 2 : 0);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(MSG_W - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t             state_q;
    logic [MSG_W-1:0]   msg [CHANNELS];
    logic [MSG_W-1:0]   shift_q;
    logic [MSG_W-1:0]   shift_nx;
    logic [MSG_W-1:0]   start_data;
    logic               order_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIT_W-1:0]   bit_q;
    logic               sel_ok;
    logic               load_ok;
    logic               first_bit;
    logic               next_bit;

    // Select decode, protected-load rule, shift-register next value and bit taps
    always_comb begin
        sel_ok     = 32'(sel) < CHANNELS;
        // The channel currently on the wire is frozen so a repeat frame stays identical
        load_ok    = init && sel_ok && !(busy && (sel == active_ch));
        // Same-cycle init+start on one channel transmits the fresh SW value
        start_data = (init && sel_ok) ? SW : msg[sel];
        shift_nx   = order_q ? {shift_q[MSG_W-2:0], 1'b0} : {1'b0, shift_q[MSG_W-1:1]};
        first_bit  = order_q ? shift_q[MSG_W-1] : shift_q[0];
        next_bit   = order_q ? shift_nx[MSG_W-1] : shift_nx[0];
    end

    // Message register bank
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg <= '{default: '0};
        end else if (load_ok) begin
            msg[sel] <= SW;
        end
    end

    // Frame sequencer with registered line, busy, done and channel outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            out       <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            active_ch <= '0;
            shift_q   <= '0;
            order_q   <= 1'b0;
            cnt_q     <= '0;
            bit_q     <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state_q != StIdle)) begin
                state_q <= StIdle;
                out     <= 1'b1;
                busy    <= 1'b0;
                cnt_q   <= '0;
                bit_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start && sel_ok) begin
                            state_q   <= StStart;
                            active_ch <= sel;
                            shift_q   <= start_data;
                            order_q   <= mode[0];
                            cnt_q     <= '0;
                            out       <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            bit_q   <= '0;
                            state_q <= StData;
                            out     <= first_bit;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            shift_q <= shift_nx;
                            if (bit_q == BIT_LAST) begin
                                state_q <= StStop;
                                out     <= 1'b1;
                                // A one-cycle stop bit is also its own final cycle
                                done    <= (DIV == 1);
                            end else begin
                                bit_q <= bit_q + 1'b1;
                                out   <= next_bit;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StStop: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (mode[1]) begin
                                state_q <= StStart;
                                shift_q <= msg[active_ch];
                                order_q <= mode[0];
                                out     <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                                out     <= 1'b1;
                                busy    <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            done  <= (cnt_q == CNT_PRE);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
